uart_tx_arbiter: RTL

Shares one UART transmitter (ready/valid byte sink, `UATransmit`-style) among `NumPorts` byte-stream requesters. Grants are round-robin and packet-granular: the winner holds the transmitter until it sends a byte marked last, or until `MaxBurst` payload bytes have gone out. Each granted burst is preceded by a one-byte header that identifies the source port, so the host can demultiplex the serial stream. The block sits between on-chip producers (debug/status/echo channels) and the single serial TX line.

---
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART byte transmitter among
// NumPorts requesters; each granted burst is prefixed with an 8'hA0|port header.
module uart_tx_arbiter #(
  parameter int NumPorts = 4,
  parameter int MaxBurst = 64
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [8*NumPorts-1:0]   InData,
  input  logic [NumPorts-1:0]     InLast,
  input  logic [NumPorts-1:0]     InValid,
  output logic [NumPorts-1:0]     InReady,
  output logic [7:0]              TxData,
  output logic                    TxValid,
  input  logic                    TxReady,
  output logic [NumPorts-1:0]     Grant,
  output logic                    Busy
);

  localparam int IdxW = $clog2(NumPorts);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HEADER = 2'd1;
  localparam logic [1:0] S_BODY   = 2'd2;

  logic [1:0]          r_state;
  logic [NumPorts-1:0] r_grant;
  logic [IdxW-1:0]     r_grant_idx;
  logic [IdxW-1:0]     r_last_grant;
  logic [7:0]          r_count;

  logic                w_found;
  logic [IdxW-1:0]     w_next_idx;
  logic [IdxW-1:0]     w_cand;
  logic                w_owner_valid;
  logic                w_owner_last;
  logic                w_body_hs;
  logic                w_burst_end;
  logic [7:0]          w_count_next;

  // Search upward from the port after the previous owner, wrapping around.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_found    = 1'b0;
    w_next_idx = '0;
    w_cand     = '0;
    for (int k = 1; k <= NumPorts; k++) begin
      w_cand = IdxW'((int'(r_last_grant) + k) % NumPorts);
      if (!w_found && InValid[w_cand]) begin
        w_found    = 1'b1;
        w_next_idx = w_cand;
      end
    end
  end

  assign w_owner_valid = InValid[r_grant_idx];
  assign w_owner_last  = InLast[r_grant_idx];
  assign w_body_hs     = (r_state == S_BODY) && w_owner_valid && TxReady;
  assign w_count_next  = r_count + 8'd1;
  assign w_burst_end   = w_owner_last || (w_count_next == 8'(MaxBurst));

  // Data path is purely combinational: InReady never looks at InValid, and
  // TxValid never looks at TxReady.
  always_comb begin
    TxData  = 8'h00;
    TxValid = 1'b0;
    InReady = '0;
    case (r_state)
      S_HEADER: begin
        TxData  = 8'hA0 | 8'(r_grant_idx);
        TxValid = 1'b1;
      end
      S_BODY: begin
        TxData  = InData[{r_grant_idx, 3'b000} +: 8];
        TxValid = w_owner_valid;
        InReady = r_grant & {NumPorts{TxReady}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_grant_idx  <= '0;
      r_last_grant <= IdxW'(NumPorts - 1);
      r_count      <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= NumPorts'(1) << w_next_idx;
            r_grant_idx <= w_next_idx;
            r_count     <= 8'd0;
            r_state     <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (TxReady) r_state <= S_BODY;
        end
        S_BODY: begin
          if (w_body_hs) begin
            r_count <= w_count_next;
            // A MaxBurst cut leaves the rest of the packet for the next grant.
            if (w_burst_end) begin
              r_state      <= S_IDLE;
              r_grant      <= '0;
              r_last_grant <= r_grant_idx;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Grant = r_grant;
  assign Busy  = (r_state != S_IDLE);

endmodule
